// File: rtl/bnn_axil_pkg.sv
// Shared types and constants for the BNN AXI4-Lite register slave.
package bnn_axil_pkg;

    localparam int unsigned ADDR_LSB = 2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        WrIdle,
        WrResp
    } wr_state_t;

    typedef enum logic {
        RdIdle,
        RdData
    } rd_state_t;

endpackage

// File: rtl/bnn_axil_reg_slave.sv
// AXI4-Lite register file for the BNN S00_AXI port with flat register outputs.
// Define BNN_AXIL_DECERR_EN to answer out-of-range indices with SLVERR instead of aliasing.
module bnn_axil_reg_slave
    import bnn_axil_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_ADDR_WIDTH = 4,
    parameter int unsigned C_NUM_REGS   = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [C_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,
    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,
    output logic [C_NUM_REGS*C_DATA_WIDTH-1:0] reg_q,
    output logic [C_NUM_REGS-1:0]              reg_wr_pulse
);

    localparam int unsigned IdxW  = C_ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned SelW  = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam int unsigned StrbW = C_DATA_WIDTH / 8;

    function automatic logic [SelW-1:0] reg_sel(input logic [IdxW-1:0] idx);
        return SelW'(32'(idx) % C_NUM_REGS);
    endfunction

    wr_state_t                 wr_state_q;
    rd_state_t                 rd_state_q;
    logic [C_DATA_WIDTH-1:0]   regs_q [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]     reg_wr_pulse_q;
    logic                      awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic                      aw_held_q, w_held_q;
    logic [IdxW-1:0]           aw_idx_q;
    logic [C_DATA_WIDTH-1:0]   w_data_q, rdata_q;
    logic [StrbW-1:0]          w_strb_q;
    logic [1:0]                bresp_q, rresp_q;

    logic                      aw_hs, w_hs, aw_have, w_have, commit, ar_hs;
    logic [IdxW-1:0]           wr_idx, rd_idx;
    logic [C_DATA_WIDTH-1:0]   wr_data, rd_data;
    logic [StrbW-1:0]          wr_strb;
    logic [SelW-1:0]           wr_sel, rd_sel;
    logic                      wr_ok, rd_ok;
    logic [1:0]                wr_resp, rd_resp;

    always_comb begin
        aw_hs   = S_AXI_AWVALID && awready_q;
        w_hs    = S_AXI_WVALID && wready_q;
        aw_have = aw_held_q || aw_hs;
        w_have  = w_held_q || w_hs;
        commit  = (wr_state_q == WrIdle) && aw_have && w_have;
        wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
        wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
        wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
        wr_sel  = reg_sel(wr_idx);
        ar_hs   = S_AXI_ARVALID && arready_q;
        rd_idx  = S_AXI_ARADDR[C_ADDR_WIDTH-1:ADDR_LSB];
        rd_sel  = reg_sel(rd_idx);
`ifdef BNN_AXIL_DECERR_EN
        wr_ok   = 32'(wr_idx) < C_NUM_REGS;
        rd_ok   = 32'(rd_idx) < C_NUM_REGS;
`else
        wr_ok   = 1'b1;
        rd_ok   = 1'b1;
`endif
        wr_resp = wr_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        rd_resp = rd_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        rd_data = rd_ok ? regs_q[rd_sel] : '0;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_state_q     <= WrIdle;
            regs_q         <= '{default: '0};
            reg_wr_pulse_q <= '0;
            awready_q      <= 1'b0;
            wready_q       <= 1'b0;
            bvalid_q       <= 1'b0;
            bresp_q        <= AXI_RESP_OKAY;
            aw_held_q      <= 1'b0;
            w_held_q       <= 1'b0;
            aw_idx_q       <= '0;
            w_data_q       <= '0;
            w_strb_q       <= '0;
        end else begin
            reg_wr_pulse_q <= '0;
            unique case (wr_state_q)
                WrIdle: begin
                    if (commit) begin
                        for (int unsigned k = 0; k < StrbW; k++) begin
                            if (wr_ok && wr_strb[k]) begin
                                regs_q[wr_sel][8*k +: 8] <= wr_data[8*k +: 8];
                            end
                        end
                        if (wr_ok) begin
                            reg_wr_pulse_q[wr_sel] <= 1'b1;
                        end
                        bresp_q    <= wr_resp;
                        bvalid_q   <= 1'b1;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b0;
                        wr_state_q <= WrResp;
                    end else begin
                        // Whichever half arrives first is parked until its partner shows up.
                        aw_held_q <= aw_have;
                        w_held_q  <= w_have;
                        awready_q <= !aw_have;
                        wready_q  <= !w_have;
                        if (aw_hs) begin
                            aw_idx_q <= S_AXI_AWADDR[C_ADDR_WIDTH-1:ADDR_LSB];
                        end
                        if (w_hs) begin
                            w_data_q <= S_AXI_WDATA;
                            w_strb_q <= S_AXI_WSTRB;
                        end
                    end
                end
                WrResp: begin
                    if (S_AXI_BREADY) begin
                        bvalid_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= WrIdle;
                    end
                end
                default: wr_state_q <= WrIdle;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rd_state_q <= RdIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= AXI_RESP_OKAY;
        end else begin
            unique case (rd_state_q)
                RdIdle: begin
                    if (ar_hs) begin
                        rdata_q    <= rd_data;
                        rresp_q    <= rd_resp;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= RdData;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                RdData: begin
                    if (S_AXI_RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RdIdle;
                    end
                end
                default: rd_state_q <= RdIdle;
            endcase
        end
    end

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg_out
        assign reg_q[C_DATA_WIDTH*i +: C_DATA_WIDTH] = regs_q[i];
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign reg_wr_pulse  = reg_wr_pulse_q;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

endmodule
